div_seq: RTL
============

Name: div_seq

Overview:
- Multi-cycle 32-bit restoring divider for DIV/DIVU.
- Responder side of the EX-stage divide handshake: EX raises start with operands, the divider iterates one quotient bit per cycle and returns {remainder, quotient}.
- EX holds the pipeline via the ctrl stall request until ready_o.
- The result feeds HI (remainder) and LO (quotient) through the ex_mem/mem_wb path.

Parameters:
- DATA_W, 32, operand width; quotient/remainder width; iteration count equals DATA_W.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- signed_div_i  input  1  1 = signed DIV, 0 = unsigned DIVU.
- opdata1_i  input  DATA_W  dividend.
- opdata2_i  input  DATA_W  divisor.
- start_i  input  1  divide request; level, held by EX until it consumes the result.
- annul_i  input  1  cancel the in-flight divide (flush).
- result_o  output  2*DATA_W  {remainder[63:32], quotient[31:0]}.
- ready_o  output  1  result valid.

Behaviour:
- Reset (rst=0, async): state=DivFree, cnt=0, result_o=0, ready_o=0, internal registers=0. Reset takes effect at any point, including mid-divide.
- States: DivFree, DivByZero, DivOn, DivEnd (2-bit encoding, in defines.v).
- DivFree transitions:
  - start_i=1, annul_i=0, opdata2_i==0 -> DivByZero.
  - start_i=1, annul_i=0, opdata2_i!=0 -> DivOn.
  - Otherwise stay; ready_o=0, result_o=0.
- Operand latching on the DivOn entry edge:
  - Latch sign flags: neg_q = signed & (op1[31]^op2[31]); neg_r = signed & op1[31].
  - Latch divisor magnitude |op2|.
  - Work register (2*DATA_W+1 bits) = {0, |op1|, 1'b0}; cnt=0.
  - |x| = two's-complement negate when signed_div_i and x[31]=1; otherwise x.
- DivOn, one step per edge while cnt<DATA_W:
  - diff = work[64:32] - {1'b0, divisor}.
  - If diff is negative: work = {work[63:0], 1'b0}.
  - Else: work = {diff[31:0], work[31:0], 1'b1}.
  - cnt++.
- DivOn finalise (cnt==DATA_W):
  - quotient = work[31:0], negated if neg_q.
  - remainder = work[64:33], negated if neg_r.
  - result_o = {remainder, quotient}; ready_o=1; -> DivEnd.
- DivOn annul: annul_i=1 on any edge -> DivFree, cnt=0, ready_o=0, result_o=0. No result is produced.
- DivByZero: next edge -> DivEnd, result_o=0, ready_o=1. No exception is raised (MIPS result is undefined; the team defines it as 0).
- DivEnd:
  - While start_i=1: hold result_o and ready_o=1.
  - start_i=0 -> DivFree on that edge, ready_o=0, result_o=0.
  - annul_i in DivEnd is ignored (the result is already final).
- Latency, start_i first sampled at edge E0:
  - Normal divide: ready_o=1 after edge E0+DATA_W+1 (33 for DATA_W=32).
  - Divide by zero: ready_o=1 after edge E0+1.
- Operand changes after E0 do not affect the in-flight divide (operands are latched).
- Boundary cases:
  - signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0 (no trap).
  - Dividend 0 -> q=0, r=0 after the full 33 cycles.
- Back-to-back divides: a new start is accepted only from DivFree, so EX must drop start_i for at least one cycle.
- start_i and annul_i both high in DivFree: annul wins; stay in DivFree.

Decomposition:
- defines.v holds:
  - State codes: DivFree=2'b00, DivByZero=2'b01, DivOn=2'b10, DivEnd=2'b11.
  - DivResultReady/DivResultNotReady, DivStart/DivStop.
  - ZeroWord and the existing RegBus.
  - DoubleRegBus (63:0) for result_o.
- No sub-module is required. A combinational div_step (one restoring iteration: work in, divisor in, work out) is natural and is the unit the bench can also test exhaustively on small widths.

Test Plan:
- Unsigned 100/7:
  - Stimulus: signed=0, op1=0x00000064, op2=0x00000007, start held.
  - Response: ready_o=1 at E0+33; result_o=0x00000002_0000000E; ready_o and result held until start drops, then 0 next edge.
- Signed -7/2:
  - Stimulus: op1=0xFFFFFFF9, op2=0x00000002.
  - Response: result_o=0xFFFFFFFF_FFFFFFFD (r=-1, q=-3).
- Signed 7/-2:
  - Response: result_o=0x00000001_FFFFFFFD.
- Signed overflow case:
  - Stimulus: op1=0x80000000, op2=0xFFFFFFFF.
  - Response: result_o=0x00000000_80000000.
- Divide by zero:
  - Stimulus: op1=0x12345678, op2=0.
  - Response: ready_o=1 at E0+1 with result_o=0; unsigned 0xFFFFFFFF/1 afterwards gives q=0xFFFFFFFF, r=0 at E0+33.
- Annul, then async reset:
  - Stimulus: annul_i pulsed at E0+10.
  - Response: ready_o never rises, state returns to DivFree; a subsequent 9/3 yields 0x00000000_00000003. Separately, dropping rst at E0+20 clears ready_o and result_o immediately without waiting for a clock edge.

Source files
------------

// File: rtl/div_seq_pkg.sv
// ============================================================================
// div_seq_pkg : shared state codes and constants for the sequential divider
// Revision    : 1.0
// ============================================================================
`default_nettype none

package div_seq_pkg;

   localparam int REG_W = 32;

   typedef enum logic [1:0] {
      DIV_FREE    = 2'b00,
      DIV_BY_ZERO = 2'b01,
      DIV_ON      = 2'b10,
      DIV_END     = 2'b11
   } div_state_t;

   localparam logic DIV_RESULT_READY     = 1'b1;
   localparam logic DIV_RESULT_NOT_READY = 1'b0;
   localparam logic DIV_START            = 1'b1;
   localparam logic DIV_STOP             = 1'b0;

   localparam logic [REG_W-1:0]   ZERO_WORD   = '0;
   localparam logic [2*REG_W-1:0] ZERO_DOUBLE = '0;

endpackage

`default_nettype wire

// File: rtl/div_seq_step.sv
// ============================================================================
// div_seq_step : one restoring-division iteration on the packed work register
// Revision     : 1.0
// ============================================================================
`default_nettype none

module div_seq_step
   import div_seq_pkg::*;
#(
   parameter int DATA_W = REG_W
) (
   input  logic [2*DATA_W:0] work_in,
   input  logic [DATA_W-1:0] divisor,
   output logic [2*DATA_W:0] work_out
);

   logic [DATA_W:0] diff;

   // Low half of the work register doubles as dividend shifter and quotient accumulator.
   always_comb begin
      diff = work_in[2*DATA_W:DATA_W] - {1'b0, divisor};
      if (diff[DATA_W]) begin
         work_out = {work_in[2*DATA_W-1:0], 1'b0};
      end else begin
         work_out = {diff[DATA_W-1:0], work_in[DATA_W-1:0], 1'b1};
      end
   end

endmodule

`default_nettype wire

// File: rtl/div_seq.sv
// ============================================================================
// div_seq  : multi-cycle restoring divider for DIV/DIVU, {remainder, quotient}
// Revision : 1.0
// ============================================================================
`default_nettype none

module div_seq
   import div_seq_pkg::*;
#(
   parameter int DATA_W = REG_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  signed_div_i,
   input  logic [DATA_W-1:0]     opdata1_i,
   input  logic [DATA_W-1:0]     opdata2_i,
   input  logic                  start_i,
   input  logic                  annul_i,
   output logic [2*DATA_W-1:0]   result_o,
   output logic                  ready_o
);

   localparam int               CNT_W    = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   div_state_t              state;
   div_state_t              state_next;
   logic [CNT_W-1:0]        cnt;
   logic [2*DATA_W:0]       work;
   logic [2*DATA_W:0]       work_step;
   logic [DATA_W-1:0]       divisor;
   logic                    neg_q;
   logic                    neg_r;
   logic [2*DATA_W-1:0]     result;
   logic                    load;
   logic                    iterate;
   logic                    finish;
   logic                    clear_res;
   logic [DATA_W-1:0]       quo_final;
   logic [DATA_W-1:0]       rem_final;

   function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x, input logic sgn);
      return (sgn && x[DATA_W-1]) ? -x : x;
   endfunction

   div_seq_step #(
      .DATA_W   (DATA_W)
   ) u_step (
      .work_in  (work),
      .divisor  (divisor),
      .work_out (work_step)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= DIV_FREE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         DIV_FREE: begin
            if (start_i == DIV_START && !annul_i) begin
               state_next = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
            end
         end
         DIV_BY_ZERO: state_next = DIV_END;
         DIV_ON: begin
            if (annul_i) begin
               state_next = DIV_FREE;
            end else if (cnt == CNT_LAST) begin
               state_next = DIV_END;
            end
         end
         DIV_END: begin
            if (start_i == DIV_STOP) begin
               state_next = DIV_FREE;
            end
         end
         default: state_next = DIV_FREE;
      endcase
   end

   always_comb begin
      load      = (state == DIV_FREE) && (state_next == DIV_ON);
      iterate   = (state == DIV_ON) && !annul_i && (cnt != CNT_LAST);
      finish    = (state == DIV_ON) && (state_next == DIV_END);
      clear_res = (state_next == DIV_FREE) || (state == DIV_BY_ZERO);
      ready_o   = (state == DIV_END) ? DIV_RESULT_READY : DIV_RESULT_NOT_READY;
   end

   assign quo_final = neg_q ? -work[DATA_W-1:0]        : work[DATA_W-1:0];
   assign rem_final = neg_r ? -work[2*DATA_W:DATA_W+1] : work[2*DATA_W:DATA_W+1];

   // Operands and sign flags are captured once so EX may change them mid-divide.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt     <= '0;
         work    <= '0;
         divisor <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         result  <= '0;
      end else begin
         if (load) begin
            neg_q   <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_r   <= signed_div_i & opdata1_i[DATA_W-1];
            divisor <= mag(opdata2_i, signed_div_i);
            work    <= {{DATA_W{1'b0}}, mag(opdata1_i, signed_div_i), 1'b0};
            cnt     <= '0;
         end else if (iterate) begin
            work <= work_step;
            cnt  <= cnt + CNT_ONE;
         end else if (state == DIV_ON && annul_i) begin
            cnt <= '0;
         end

         if (finish) begin
            result <= {rem_final, quo_final};
         end else if (clear_res) begin
            result <= '0;
         end
      end
   end

   assign result_o = result;

endmodule

`default_nettype wire
